kuz_round_engine: RTL and testbench

Iterative Kuznyechik (GOST R 34.12-2015) block engine: takes one 128-bit block plus a full round-key schedule and runs all ten rounds (key xor, non-linear S layer, linear L layer) on a single state register. It generalises the single fixed stage with a parametrised linear-layer unroll and a valid/ready handshake on both sides. It sits between the key-schedule block and the mode/stream wrapper.

---
 rtl/kuz_round_engine.sv | 214 +++++++++++++++++++++
 tb/tb_kuz_round_engine.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/kuz_round_engine.sv
// kuz_round_engine: iterative Kuznyechik (GOST R 34.12-2015) block engine.
// Runs all ten rounds on one 128-bit state register. The linear layer is
// unrolled LSTEPS R-steps per cycle. Valid/ready handshakes on input and output.
// Optional macro KUZ_DECRYPT_EN compiles in the decrypt path (DX/LINV/SXI,
// inverse S table, R^-1 datapath); without it every block is encrypted.
module kuz_round_engine #(
    parameter int unsigned LSTEPS = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic          mode_i,
    input  logic [127:0]  data_i,
    input  logic [1279:0] keys_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [127:0]  data_o
);

    if (!(LSTEPS == 1 || LSTEPS == 2 || LSTEPS == 4 || LSTEPS == 8 || LSTEPS == 16)) begin : g_bad_lsteps
        $error("kuz_round_engine: LSTEPS must be 1, 2, 4, 8 or 16");
    end

    localparam int unsigned N        = 16 / LSTEPS;
    localparam logic [3:0]  CNT_LAST = 4'(N - 1);

    // l-function coefficients, byte [127:120] multiplies a15
    localparam logic [127:0] LCOEF = 128'h94_20_85_10_C2_C0_01_FB_01_C0_C2_10_85_20_94_01;

    localparam logic [7:0] PI [256] = '{
        252, 238, 221,  17, 207, 110,  49,  22, 251, 196, 250, 218,  35, 197,   4,  77,
        233, 119, 240, 219, 147,  46, 153, 186,  23,  54, 241, 187,  20, 205,  95, 193,
        249,  24, 101,  90, 226,  92, 239,  33, 129,  28,  60,  66, 139,   1, 142,  79,
          5, 132,   2, 174, 227, 106, 143, 160,   6,  11, 237, 152, 127, 212, 211,  31,
        235,  52,  44,  81, 234, 200,  72, 171, 242,  42, 104, 162, 253,  58, 206, 204,
        181, 112,  14,  86,   8,  12, 118,  18, 191, 114,  19,  71, 156, 183,  93, 135,
         21, 161, 150,  41,  16, 123, 154, 199, 243, 145, 120, 111, 157, 158, 178, 177,
         50, 117,  25,  61, 255,  53, 138, 126, 109,  84, 198, 128, 195, 189,  13,  87,
        223, 245,  36, 169,  62, 168,  67, 201, 215, 121, 214, 246, 124,  34, 185,   3,
        224,  15, 236, 222, 122, 148, 176, 188, 220, 232,  40,  80,  78,  51,  10,  74,
        167, 151,  96, 115,  30,   0,  98,  68,  26, 184,  56, 130, 100, 159,  38,  65,
        173,  69,  70, 146,  39,  94,  85,  47, 140, 163, 165, 125, 105, 213, 149,  59,
          7,  88, 179,  64, 134, 172,  29, 247,  48,  55, 107, 228, 136, 217, 231, 137,
        225,  27, 131,  73,  76,  63, 248, 254, 141,  83, 170, 144, 202, 216, 133,  97,
         32, 113, 103, 164,  45,  43,   9,  91, 203, 155,  37, 208, 190, 229, 108,  82,
         89, 166, 116, 210, 230, 244, 180, 192, 209, 102, 175, 194,  57,  75,  99, 182
    };

`ifdef KUZ_DECRYPT_EN
    typedef enum logic [2:0] {IDLE, SX, LIN, FIN, DONE, DX, LINV, SXI} state_t;
`else
    typedef enum logic [2:0] {IDLE, SX, LIN, FIN, DONE} state_t;
`endif

    state_t        state_q, state_d;
    logic [127:0]  st_q, st_d;
    logic [3:0]    rnd_q, rnd_d;
    logic [3:0]    cnt_q, cnt_d;

    // GF(2^8) multiply, reduction polynomial x^8+x^7+x^6+x+1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'hC3) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [7:0] l_fn(input logic [127:0] a);
        logic [7:0] acc;
        acc = '0;
        for (int unsigned i = 0; i < 16; i++)
            acc = acc ^ gf_mul(a[8*i +: 8], LCOEF[8*i +: 8]);
        return acc;
    endfunction

    function automatic logic [127:0] s_fwd(input logic [127:0] a);
        logic [127:0] r;
        r = '0;
        for (int unsigned i = 0; i < 16; i++)
            r[8*i +: 8] = PI[a[8*i +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] lin_fwd(input logic [127:0] a);
        logic [127:0] t;
        t = a;
        for (int unsigned i = 0; i < LSTEPS; i++)
            t = {l_fn(t), t[127:8]};
        return t;
    endfunction

`ifdef KUZ_DECRYPT_EN
    function automatic logic [2047:0] build_pi_inv();
        logic [2047:0] t;
        t = '0;
        for (int unsigned i = 0; i < 256; i++)
            t[{PI[i], 3'd0} +: 8] = 8'(i);
        return t;
    endfunction

    localparam logic [2047:0] PI_INV = build_pi_inv();

    function automatic logic [127:0] s_inv(input logic [127:0] a);
        logic [127:0] r;
        r = '0;
        for (int unsigned i = 0; i < 16; i++)
            r[8*i +: 8] = PI_INV[{a[8*i +: 8], 3'd0} +: 8];
        return r;
    endfunction

    // R^-1: shift up one byte, new a0 = l(a14..a0, a15)
    function automatic logic [127:0] lin_inv(input logic [127:0] a);
        logic [127:0] t;
        t = a;
        for (int unsigned i = 0; i < LSTEPS; i++)
            t = {t[119:0], l_fn({t[119:0], t[127:120]})};
        return t;
    endfunction
`else
    logic mode_unused;
    assign mode_unused = mode_i;
`endif

    // next-state and datapath for the round sequencer
    always_comb begin
        state_d = state_q;
        st_d    = st_q;
        rnd_d   = rnd_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    st_d  = data_i;
                    rnd_d = '0;
                    cnt_d = '0;
`ifdef KUZ_DECRYPT_EN
                    state_d = mode_i ? DX : SX;
`else
                    state_d = SX;
`endif
                end
            end
            SX: begin
                st_d    = s_fwd(st_q ^ keys_i[{rnd_q, 7'd0} +: 128]);
                state_d = LIN;
            end
            LIN: begin
                st_d = lin_fwd(st_q);
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    rnd_d   = rnd_q + 4'd1;
                    state_d = (rnd_q == 4'd8) ? FIN : SX;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            FIN: begin
                st_d    = st_q ^ keys_i[1279:1152];
                state_d = DONE;
            end
            DONE: begin
                if (out_ready_i) state_d = IDLE;
            end
`ifdef KUZ_DECRYPT_EN
            DX: begin
                st_d    = st_q ^ keys_i[1279:1152];
                rnd_d   = 4'd9;
                state_d = LINV;
            end
            LINV: begin
                st_d = lin_inv(st_q);
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = SXI;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            SXI: begin
                st_d    = s_inv(st_q) ^ keys_i[{rnd_q - 4'd1, 7'd0} +: 128];
                rnd_d   = rnd_q - 4'd1;
                state_d = (rnd_q == 4'd1) ? DONE : LINV;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // state and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            st_q    <= '0;
            rnd_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            rnd_q   <= rnd_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = (state_q == DONE);
    assign data_o      = st_q;

endmodule

// File: tb/tb_kuz_round_engine.sv
// Testbench for kuz_round_engine: five instances (LSTEPS 1,2,4,8,16) share
// data/keys/mode/out_ready; each has its own in_valid and a scoreboard queue.
module tb_kuz_round_engine;

    localparam int unsigned NDUT = 5;

    localparam logic [127:0] PT = 128'h1122334455667700ffeeddccbbaa9988;
    localparam logic [127:0] CT = 128'h7f679d90bebc24305a468d42b9d4edcd;
    localparam logic [1279:0] KEYS = {
        128'h72e9dd7416bcf45b755dbaa88e4a4043,
        128'hbb44e25378c73123a5f32f73cdb6e517,
        128'h5a7925017b9fdd3ed72a91a22286f984,
        128'h51e640757e8745de705727265a0098b1,
        128'hbd079435165c6432b532e82834da581b,
        128'h57646468c44a5e28d3e59246f429f1ac,
        128'h3d4553d8e9cfec6815ebadc40a9ffd04,
        128'hdb31485315694343228d6aef8cc78c44,
        128'hfedcba98765432100123456789abcdef,
        128'h8899aabbccddeeff0011223344556677
    };

    typedef struct packed {
        logic [127:0] d;
        int unsigned  acc;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [NDUT-1:0]   iv;
    logic [NDUT-1:0]   ir;
    logic [NDUT-1:0]   ov;
    logic              mode;
    logic              out_ready;
    logic [127:0]      din;
    logic [1279:0]     keys;
    logic [127:0]      dout [NDUT];

    exp_t              sb [NDUT][$];
    int unsigned       cyc = 0;
    int                total = 0;
    int                bad = 0;

    always #5 clk = ~clk;

    // edge counter shared by driver and monitors for latency measurement
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    function automatic int unsigned lat_of(input int unsigned g);
        return 9 * ((16 >> g) + 1) + 1;
    endfunction

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        kuz_round_engine #(.LSTEPS(1 << g)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .in_valid_i (iv[g]),
            .in_ready_o (ir[g]),
            .mode_i     (mode),
            .data_i     (din),
            .keys_i     (keys),
            .out_valid_o(ov[g]),
            .out_ready_i(out_ready),
            .data_o     (dout[g])
        );

        logic ov_prev;

        // latency check on rising out_valid, data check on output handshake
        always @(negedge clk or posedge rst) begin
            if (rst) begin
                ov_prev <= 1'b0;
            end else begin
                if (ov[g] && !ov_prev) begin
                    if (sb[g].size() == 0)
                        check_eq($sformatf("unexp_out[L%0d]", 1 << g), 128'(sb[g].size()), 128'd1);
                    else
                        check_eq($sformatf("latency[L%0d]", 1 << g), 128'(cyc - sb[g][0].acc), 128'(lat_of(g)));
                end
                if (ov[g] && out_ready && sb[g].size() != 0) begin
                    check_eq($sformatf("data[L%0d]", 1 << g), dout[g], sb[g][0].d);
                    void'(sb[g].pop_front());
                end
                ov_prev <= ov[g];
            end
        end
    end

    task automatic submit(input logic [NDUT-1:0] mask, input logic [127:0] d, input logic m,
                          input logic [127:0] exp, input bit push, output int unsigned acc);
        int unsigned w;
        @(posedge clk); #1;
        din  = d;
        mode = m;
        iv   = mask;
        w    = 0;
        @(negedge clk);
        while (((ir & mask) != mask) && w < 400) begin
            @(negedge clk);
            w++;
        end
        if ((ir & mask) != mask) begin
            check_eq("accept_timeout", 128'(ir & mask), 128'(mask));
            iv  = '0;
            acc = 0;
            return;
        end
        @(posedge clk); #1;
        iv  = '0;
        acc = cyc;
        if (push)
            for (int unsigned g = 0; g < NDUT; g++)
                if (mask[g]) sb[g].push_back('{d: exp, acc: cyc});
    endtask

    function automatic bit sb_busy();
        for (int unsigned g = 0; g < NDUT; g++)
            if (sb[g].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drain(input int unsigned max_cyc);
        int unsigned w;
        w = 0;
        while (sb_busy() && w < max_cyc) begin
            @(negedge clk);
            w++;
        end
        for (int unsigned g = 0; g < NDUT; g++)
            if (sb[g].size() != 0) begin
                check_eq($sformatf("drain_timeout[%0d]", g), 128'(sb[g].size()), 128'd0);
                sb[g].delete();
            end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned a1, a2;
        int unsigned w;
        rst       = 1'b1;
        iv        = '0;
        mode      = 1'b0;
        out_ready = 1'b1;
        din       = '0;
        keys      = KEYS;
        #12;
        check_eq("rst_ready", 128'(ir), 128'({NDUT{1'b1}}));
        check_eq("rst_valid", 128'(ov), 128'd0);
        for (int unsigned g = 0; g < NDUT; g++)
            check_eq($sformatf("rst_data[%0d]", g), dout[g], 128'd0);
        @(negedge clk);
        rst = 1'b0;

        // encrypt on all unroll factors
        submit('1, PT, 1'b0, CT, 1'b1, a1);
        drain(300);

        // decrypt, or encrypt regardless of mode_i when the decrypt path is absent
`ifdef KUZ_DECRYPT_EN
        submit('1, CT, 1'b1, PT, 1'b1, a1);
`else
        submit('1, PT, 1'b1, CT, 1'b1, a1);
`endif
        drain(300);

        // back-to-back accept on LSTEPS=16
        submit(5'h10, PT, 1'b0, CT, 1'b1, a1);
        submit(5'h10, PT, 1'b0, CT, 1'b1, a2);
        check_eq("period", 128'(a2 - a1), 128'd21);
        drain(100);

        // single R step on LSTEPS=1 with zero keys: S maps A5->00, 2D->01
        keys = '0;
        submit(5'h01, {{14{8'hA5}}, 8'h2D, 8'hA5}, 1'b0, '0, 1'b0, a1);
        @(posedge clk); #1;
        check_eq("r_unit_sx", g_dut[0].u_dut.st_q, 128'h0000_0000_0000_0000_0000_0000_0000_0100);
        @(posedge clk); #1;
        check_eq("r_unit_lin", g_dut[0].u_dut.st_q, 128'h9400_0000_0000_0000_0000_0000_0000_0001);
        rst = 1'b1;
        #2;
        @(negedge clk);
        rst  = 1'b0;
        keys = KEYS;

        // backpressure on LSTEPS=16
        out_ready = 1'b0;
        submit(5'h10, PT, 1'b0, CT, 1'b1, a1);
        w = 0;
        while (!ov[4] && w < 60) begin
            @(negedge clk);
            w++;
        end
        check_eq("bp_valid_rise", 128'(ov[4]), 128'd1);
        for (int unsigned k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            iv[4] = k[0];
            @(negedge clk);
            check_eq("bp_valid", 128'(ov[4]), 128'd1);
            check_eq("bp_data", dout[4], CT);
            check_eq("bp_ready", 128'(ir[4]), 128'd0);
        end
        @(posedge clk); #1;
        iv        = '0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("bp_release_ready", 128'(ir[4]), 128'd1);
        check_eq("bp_release_valid", 128'(ov[4]), 128'd0);
        check_eq("bp_sb_empty", 128'(sb[4].size()), 128'd0);

        // asynchronous reset in the middle of a block
        submit(5'h10, PT, 1'b0, CT, 1'b0, a1);
        repeat (5) @(posedge clk);
        #2;
        check_eq("mid_busy", 128'(ir[4]), 128'd0);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_ready", 128'(ir[4]), 128'd1);
        check_eq("mid_rst_valid", 128'(ov[4]), 128'd0);
        check_eq("mid_rst_data", dout[4], 128'd0);
        @(negedge clk);
        rst = 1'b0;
        submit(5'h10, PT, 1'b0, CT, 1'b1, a1);
        drain(100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
